// File: rtl/led_disp_pkg.sv
// Shared constants for the seconds display: segment patterns,
// converter state encoding and the double-dabble step.
package led_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Active-high gfedcba patterns
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5) begin
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/led_sec_display_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// A start in DONE chains straight into the next conversion.
module bin2bcd_seq
    import led_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shift_d = {12'b0, bin};
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                shift_d = dabble_step(shift_q);
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = shift_q[19:8];

endmodule

// File: rtl/led_sec_display.sv
// 3-digit multiplexed 7-segment readout of the controller's seconds value,
// with leading-zero blanking and selectable pin polarity.
module led_sec_display
    import led_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bits,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [7:0]    bits_q;
    logic [7:0]    last_q, last_d;
    logic [7:0]    cap_q, cap_d;
    logic          valid_q, valid_d;
    logic [11:0]   disp_q, disp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;

    logic          conv_busy, conv_done, start;
    logic [11:0]   conv_bcd;
    logic [7:0]    ref_val;
    logic          ref_vld;
    logic [3:0]    nib;
    logic          show;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bits_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        bits_q <= bits;
    end

    always_comb begin
        // In DONE the captured value is about to become last_q
        ref_val = conv_done ? cap_q : last_q;
        ref_vld = conv_done | valid_q;
        start   = (!conv_busy || conv_done) &&
                  (!ref_vld || (bits_q != ref_val));
        cap_d   = start ? bits_q : cap_q;

        disp_d  = disp_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (conv_done) begin
            disp_d  = conv_bcd;
            last_d  = cap_q;
            valid_d = 1'b1;
        end

        presc_d = presc_q + PW'(1);
        digit_d = digit_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end

        nib  = disp_q[3:0];
        show = 1'b0;
        case (digit_q)
            2'd0: begin
                nib  = disp_q[3:0];
                show = 1'b1;
            end
            2'd1: begin
                nib  = disp_q[7:4];
                show = (disp_q[11:8] != 4'd0) || (disp_q[7:4] != 4'd0);
            end
            2'd2: begin
                nib  = disp_q[11:8];
                show = (disp_q[11:8] != 4'd0);
            end
            default: show = 1'b0;
        endcase

        an_d  = 3'b000;
        seg_d = SEG_OFF;
        if (!blank && show) begin
            an_d  = 3'b001 << digit_q;
            seg_d = seg_decode(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            disp_q  <= '0;
            presc_q <= '0;
            digit_q <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= 3'b000;
        end else begin
            last_q  <= last_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            disp_q  <= disp_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg  = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign an   = SEG_ACTIVE_LOW ? ~an_q : an_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_led_sec_display.sv
// Directed bench for led_sec_display: an active-high and an active-low
// instance share stimulus and are checked against hand-computed digits.
module tb_led_sec_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blank = 1'b0;
    logic [7:0] bits = 8'd0;
    logic [6:0] seg, seg_n;
    logic [2:0] an, an_n;
    logic       busy, busy_n;

    int n_chk = 0;
    int n_err = 0;
    int k = 0;

    always #5 clk = ~clk;

    led_sec_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .bits(bits), .blank(blank),
        .seg(seg), .an(an), .busy(busy)
    );

    led_sec_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .bits(bits), .blank(blank),
        .seg(seg_n), .an(an_n), .busy(busy_n)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) k = 0;
        else k++;
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic exp_out(input logic [11:0] v, input int kk,
                           input logic bl, output logic [2:0] ea,
                           output logic [6:0] es);
        int dig;
        logic [3:0] nb;
        logic sh;
        ea = 3'b000;
        es = 7'h00;
        if (kk > 0) begin
            dig = ((kk - 1) / 4) % 3;
            if (dig == 0) begin
                nb = v[3:0]; sh = 1'b1;
            end else if (dig == 1) begin
                nb = v[7:4]; sh = (v[11:8] != 0) || (v[7:4] != 0);
            end else begin
                nb = v[11:8]; sh = (v[11:8] != 0);
            end
            if (!bl && sh) begin
                ea = 3'b001 << dig;
                es = seg_of(nb);
            end
        end
    endtask

    task automatic scan_check(input string tag, input logic [11:0] v,
                              input int n);
        logic [2:0] ea, ean;
        logic [6:0] es, esn;
        for (int i = 0; i < n; i++) begin
            tick();
            exp_out(v, k, blank, ea, es);
            ean = ~ea;
            esn = ~es;
            chk({tag, ".dig"}, dut.digit_q, (k / 4) % 3);
            chk({tag, ".an"}, an, ea);
            chk({tag, ".seg"}, seg, es);
            chk({tag, ".an_n"}, an_n, ean);
            chk({tag, ".seg_n"}, seg_n, esn);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".disp"}, dut.disp_q, 0);
        chk({tag, ".an"}, an, 3'b000);
        chk({tag, ".seg"}, seg, 7'h00);
        chk({tag, ".an_n"}, an_n, 3'b111);
        chk({tag, ".seg_n"}, seg_n, 7'h7F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nchg, low;
        logic [11:0] prev, c0, c1;

        rst = 1'b1;
        bits = 8'd105;
        repeat (3) tick();
        reset_check("t1.rst");
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy) nb++;
        end
        chk("t1.busy_cycles", nb, 9);
        chk("t1.disp", dut.disp_q, 12'h105);
        scan_check("t1", 12'h105, 12);

        bits = 8'd7;
        repeat (12) tick();
        chk("t2.disp", dut.disp_q, 12'h007);
        scan_check("t2", 12'h007, 12);

        bits = 8'd255;
        repeat (12) tick();
        chk("t3.disp255", dut.disp_q, 12'h255);
        scan_check("t3a", 12'h255, 12);
        bits = 8'd0;
        repeat (12) tick();
        chk("t3.disp0", dut.disp_q, 12'h000);
        scan_check("t3b", 12'h000, 12);

        bits = 8'd60;
        tick();
        tick();
        chk("t4.start", busy, 1);
        tick();
        tick();
        bits = 8'd45;
        prev = dut.disp_q;
        nchg = 0;
        low = 0;
        c0 = 12'hFFF;
        c1 = 12'hFFF;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dut.disp_q != prev) begin
                if (nchg == 0) c0 = dut.disp_q;
                if (nchg == 1) c1 = dut.disp_q;
                nchg++;
                prev = dut.disp_q;
            end
            if (!busy && dut.disp_q != 12'h045) low++;
        end
        chk("t4.nchg", nchg, 2);
        chk("t4.first", c0, 12'h060);
        chk("t4.second", c1, 12'h045);
        chk("t4.busy_gap", low, 0);
        scan_check("t4", 12'h045, 12);

        blank = 1'b1;
        scan_check("t5.blank", 12'h045, 20);
        for (int i = 0; i < 4 && (k % 4) != 2; i++) tick();
        blank = 1'b0;
        scan_check("t5.rel", 12'h045, 8);

        bits = 8'd99;
        for (int i = 0; i < 5 && !busy; i++) tick();
        chk("t6.busy", busy, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        reset_check("t6.rst");
        rst = 1'b0;
        repeat (11) tick();
        chk("t6.disp", dut.disp_q, 12'h099);
        scan_check("t6", 12'h099, 12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/led_sec_display.md
Name: led_sec_display

Overview:
- Drives the countdown-seconds readout from the traffic light controller's 8-bit `bits` output onto a 3-digit multiplexed 7-segment display.
- Converts binary to BCD with a sequential shift-add-3 (double-dabble) engine.
- Scans the digits at a parameterised rate and blanks leading zeros.
- Sits between the traffic controller and the board LED pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays selected. Minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = seg/an pins active-low, 0 = active-high.

Ports:
- clk  in  1  system clock (fast; not the 1 Hz `sec`)
- rst  in  1  synchronous, active-high reset
- bits  in  8  seconds value from the traffic controller (0..255)
- blank  in  1  forces the whole display dark; scanning continues
- seg  out  7  segments {g,f,e,d,c,b,a}
- an  out  3  digit enables, one-hot; an[0]=ones, an[1]=tens, an[2]=hundreds
- busy  out  1  high while a conversion is in progress

Behaviour:
Reset (rst high at a clk edge):
- State goes to IDLE; disp_bcd=0; prescaler=0; digit index=0; busy=0.
- seg and an are driven inactive.
- The "last converted" valid flag is cleared, so the first IDLE cycle after reset always starts a conversion.
- rst mid-conversion aborts the conversion; the partial result is discarded.

Input capture:
- bits is registered into bits_q every cycle.

Converter FSM (states IDLE, CONV, DONE):
- IDLE: if !valid or bits_q != last_val: load shift reg {12'b0, bits_q}, load a copy of the value, set shift count 0, go to CONV.
- CONV, 8 cycles: on each cycle, add 3 to every BCD nibble >= 5, then shift the 20-bit register left by 1. When the count reaches 7 after the shift, go to DONE.
- DONE, 1 cycle: disp_bcd <= BCD[11:0]; last_val <= captured value; valid <= 1; go to IDLE.
- busy = (state != IDLE), registered.
- Latency: a bits change at edge N is visible in disp_bcd at edge N+11 at the latest.
- bits changes during CONV/DONE are not sampled into the engine. On returning to IDLE the mismatch is detected and a new conversion starts.
- disp_bcd only ever holds complete results; intermediate values never appear.

Scanner:
- The prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→0.
- From the first cycle after reset, digit 0 is selected.

Output:
- seg/an are registered, one cycle after the digit index/disp_bcd.
- Leading-zero blanking:
  - hundreds is blank if it is 0;
  - tens is blank if hundreds = 0 and tens = 0;
  - ones is never blank.
- A blanked digit has its an deasserted and seg = SEG_OFF.
- blank=1: all an deasserted and seg = SEG_OFF; the converter and scanner keep running.
- Polarity: the logical values are inverted at the output when SEG_ACTIVE_LOW=1.
- BCD nibbles above 9 cannot occur. If one does, seg shows SEG_OFF.

Decomposition:
- Package/include led_disp_pkg holds:
  - SEG_0..SEG_9 patterns (active-high gfedcba: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F);
  - SEG_OFF=7'h00;
  - the FSM state encodings IDLE/CONV/DONE.
- One sub-module, bin2bcd_seq, holds the converter FSM:
  - inputs: clk, rst, start, bin[7:0];
  - outputs: busy, done pulse, bcd[11:0].
- The top holds the change detection, scanner, blanking and pin polarity.

Test Plan (SCAN_DIV=4, SEG_ACTIVE_LOW=0):
1. Reset, then bits=105 → busy high for 9 cycles; disp_bcd=12'h105 by edge 11. an sequences 001,010,100 with 4 cycles each. seg = 6D with an=001, SEG_OFF-free 3F with an=010, 06 with an=100.
2. bits=7 → only an=001 is ever asserted, with seg=07. During the tens/hundreds slots, an=000 and seg=00.
3. bits=255 → disp_bcd=12'h255; seg shows 6D, 6D, 5B across the three slots. bits=0 → only ones shows 3F.
4. bits=60, then bits=45 three cycles into CONV → disp_bcd goes 12'h060 then 12'h045, with no other value between. busy stays high until the second DONE.
5. blank=1 for 20 cycles → an=000 and seg=00 throughout; the digit index keeps advancing. Released mid-slot → the correct digit appears on the next cycle.
6. rst pulsed mid-CONV with bits=99 → next cycle busy=0, disp_bcd=0, seg/an inactive. After release, a conversion starts and disp_bcd=12'h099 by edge 11. SEG_ACTIVE_LOW=1 rerun of test 1 → seg/an bitwise inverted.
